data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait cycles between request acceptance and response (range 0..15).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store word, 0 = load word.
REQ-007 SHALL have port req_addr  input  5  byte address into the 32-byte data memory.
REQ-008 SHALL have port req_wdata  input  32  store data.
REQ-009 SHALL have port resp_valid  output  1  response presented.
REQ-010 SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-011 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  request was misaligned and was not performed.

Function
REQ-013 SHALL hold a 32 x 8-bit byte-addressed memory, big-endian: word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}, mem[A] = bits 31:24.
REQ-014 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE, resp_valid = 1 only in RESP.
REQ-015 SHALL accept a request on a rising edge where req_valid & req_ready, capturing req_write, req_addr and req_wdata.
REQ-016 On acceptance: WAIT_CYCLES = 0 -> RESP; otherwise -> WAIT with the wait counter loaded with WAIT_CYCLES-1.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at count 0 -> RESP on the next edge.
REQ-018 resp_valid SHALL assert exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-019 On the transition into RESP, a store with captured addr[1:0] = 0 SHALL write the four bytes, and a load with addr[1:0] = 0 SHALL register resp_rdata from the memory contents at that edge.
REQ-020 Captured addr[1:0] != 0 SHALL set resp_err = 1 and resp_rdata = 0, with memory unchanged.
REQ-021 resp_valid, resp_rdata and resp_err SHALL remain stable in RESP until resp_ready = 1; on that edge -> IDLE.
REQ-022 No request SHALL be accepted on the same edge a response is consumed; the minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
REQ-023 A load following a store to the same word SHALL return the stored value.
REQ-024 req_* inputs SHALL be ignored outside IDLE; changes after acceptance SHALL have no effect.
REQ-025 Byte address arithmetic SHALL be 5-bit modulo 32; only aligned addresses (0,4,...,28) access memory, so no wrap occurs on a performed access.
REQ-026 Store responses SHALL return resp_rdata = 0 and resp_err = 0.

Reset
REQ-027 rst_n = 0 SHALL immediately force state IDLE, counter 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, and clear all 32 memory bytes to 0.
REQ-028 Reset during WAIT or RESP SHALL abandon the transaction with no memory write, and no response SHALL be issued after release.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package data_mem_pkg SHALL hold MEM_BYTES = 32, ADDR_W = 5, DATA_W = 32 and the state enum {IDLE, WAIT, RESP}.
REQ-031 The byte array and its big-endian word read/write logic SHALL be one sub-module, be_word_mem; the FSM, counter and handshake stay in data_mem_responder.

Verification
REQ-032 Reset, store 0xDEADBEEF at addr 8, then load addr 8 -> rdata 0xDEADBEEF; bytes 8..11 = DE,AD,BE,EF; both resp_valid assert 3 cycles after acceptance (WAIT_CYCLES = 2).
REQ-033 Load addr 6 -> resp_err = 1, rdata 0; then load addr 4 -> 0x00000000 (memory untouched).
REQ-034 Hold resp_ready = 0 for 5 cycles in RESP with req_valid = 1 -> response stable, req_ready = 0, no second acceptance; after consumption, IDLE for one cycle before the next acceptance.
REQ-035 WAIT_CYCLES = 0: store 0x12345678 at addr 28, load addr 28 -> resp_valid 1 cycle after each acceptance; rdata 0x12345678.
REQ-036 Assert rst_n = 0 mid-WAIT of a store 0xFFFFFFFF at addr 0 -> outputs reset asynchronously; after release, load addr 0 -> 0x00000000 and no stray response.
REQ-037 Change req_addr and req_wdata every cycle during WAIT -> the response and memory reflect only the values captured at acceptance.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and sizes for the data memory responder and its byte-array memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_mem_pkg;

  localparam int MEM_BYTES = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // One load/store request as captured on acceptance.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Only word-aligned byte addresses are allowed to touch memory.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/be_word_mem.sv
// 32-byte big-endian memory: combinational word read, single-edge word write.
// Latency: read is combinational; write lands on the clock edge with wr_en high.
// Backpressure: none; always ready for a read or a write.
module be_word_mem
  import data_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]        mem [MEM_BYTES];
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] addr_p2;
  logic [ADDR_W-1:0] addr_p3;

  // Byte offsets wrap modulo 32; the caller only writes aligned words so no wrap is ever exercised on a write.
  assign addr_p1 = addr + ADDR_W'(1);
  assign addr_p2 = addr + ADDR_W'(2);
  assign addr_p3 = addr + ADDR_W'(3);

  // Most significant byte lives at the lowest address.
  assign rdata = {mem[addr], mem[addr_p1], mem[addr_p2], mem[addr_p3]};

  // Clear every byte on reset, otherwise write all four bytes of the word when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[addr]    <= wdata[31:24];
      mem[addr_p1] <= wdata[23:16];
      mem[addr_p2] <= wdata[15:8];
      mem[addr_p3] <= wdata[7:0];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a 32-byte big-endian memory.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
// Backpressure: response held stable until resp_ready; no new request taken until back in IDLE.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  req_t             req_q;
  req_t             req_in;
  req_t             acc;
  logic             acc_ok;
  logic             enter_resp;
  logic             mem_wr_en;
  logic [DATA_W-1:0] mem_rdata;

  assign req_in = {req_write, req_addr, req_wdata};

  // With zero wait cycles the memory access happens on the accepting edge, so it
  // must use the live request; otherwise it uses the copy captured at acceptance.
  assign acc    = (state == IDLE) ? req_in : req_q;
  assign acc_ok = is_aligned(acc.addr);

  assign enter_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == '0));
  assign mem_wr_en  = enter_resp && acc.write && acc_ok;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  be_word_mem u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (mem_wr_en),
    .addr  (acc.addr),
    .wdata (acc.wdata),
    .rdata (mem_rdata)
  );

  // Handshake FSM: capture request, count down the wait, register the response, hold it until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= req_in;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_err   <= !acc_ok;
              resp_rdata <= (acc_ok && !acc.write) ? mem_rdata : '0;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_err   <= !acc_ok;
            resp_rdata <= (acc_ok && !acc.write) ? mem_rdata : '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a transaction-level reference model.
// Latency: checks resp_valid timing against WAIT_CYCLES for a 2-wait and a 0-wait instance.
// Backpressure: exercises held responses and request changes while busy.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tb_valid;
  logic        sel0;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        req_valid,  req_ready,  resp_valid,  resp_err;
  logic [31:0] resp_rdata;
  logic        req_valid0, req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  // Request valid is steered to exactly one instance; the other inputs are shared.
  assign req_valid  = tb_valid & ~sel0;
  assign req_valid0 = tb_valid & sel0;

  data_mem_responder #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for the WAIT_CYCLES=2 instance: one transaction in flight,
  // response due W edges after acceptance, store committed when the response appears.
  logic [7:0]  m_mem [32];
  bit          m_busy;
  int          cyc;
  int          m_acc;
  bit          m_wr;
  bit          m_err;
  int          m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      cyc    = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (req_valid) begin
          m_busy  = 1'b1;
          m_acc   = cyc;
          m_wr    = req_write;
          m_addr  = int'(req_addr);
          m_wdata = req_wdata;
          m_err   = (m_addr % 4) != 0;
          if (m_err || m_wr) m_rdata = 32'h0;
          else m_rdata = {m_mem[m_addr], m_mem[m_addr+1], m_mem[m_addr+2], m_mem[m_addr+3]};
        end
      end else if (cyc > m_acc + W && resp_ready) begin
        m_busy = 1'b0;
      end
      if (m_busy && cyc == m_acc + W && m_wr && !m_err) begin
        for (int k = 0; k < 4; k++) m_mem[m_addr+k] = m_wdata[31-8*k -: 8];
      end
    end
  end

  // Per-cycle comparison of the 2-wait instance against the model.
  always @(negedge clk) begin
    bit ev;
    if (mon_en) begin
      if (!rst_n) begin
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
      end else begin
        ev = m_busy && (cyc >= m_acc + W);
        chk("mdl_req_ready", req_ready, !m_busy);
        chk("mdl_resp_valid", resp_valid, ev);
        if (ev) begin
          chk("mdl_resp_rdata", resp_rdata, m_rdata);
          chk("mdl_resp_err", resp_err, m_err);
        end
      end
    end
  end

  // Issue one request to the selected instance and consume its response after
  // `hold` stalled cycles. With scramble set, req_valid stays high and the
  // address/data wander while the responder is busy. Entered and left at posedge+2.
  task automatic do_txn(input bit s, input bit wr, input logic [4:0] a, input logic [31:0] d,
                        input int hold, input bit scramble,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    sel0 = s; req_write = wr; req_addr = a; req_wdata = d; tb_valid = 1'b1;
    guard = 0;
    while (!(s ? req_ready0 : req_ready) && guard < 20) begin
      @(posedge clk); #2; guard++;
    end
    chk("accept_ready", s ? req_ready0 : req_ready, 1);
    @(posedge clk); #2;
    if (!scramble) tb_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      if (scramble) begin req_addr = 5'($urandom); req_wdata = $urandom; end
      @(negedge clk); lat++;
      if (s ? resp_valid0 : resp_valid) break;
      @(posedge clk); #2;
    end
    chk("resp_seen", s ? resp_valid0 : resp_valid, 1);
    rd = s ? resp_rdata0 : resp_rdata;
    er = s ? resp_err0 : resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      if (scramble) begin req_addr = 5'($urandom); req_wdata = $urandom; end
      @(negedge clk);
      chk("stall_valid", s ? resp_valid0 : resp_valid, 1);
      chk("stall_rdata", s ? resp_rdata0 : resp_rdata, rd);
      chk("stall_err", s ? resp_err0 : resp_err, er);
      chk("stall_req_ready", s ? req_ready0 : req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0;
    tb_valid   = 1'b0;
    @(negedge clk);
    chk("post_idle_ready", s ? req_ready0 : req_ready, 1);
    chk("post_idle_valid", s ? resp_valid0 : resp_valid, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst_n = 1'b1; tb_valid = 1'b0; sel0 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk); #2;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst0_req_ready", req_ready0, 1);
    chk("rst0_resp_valid", resp_valid0, 0);
    chk("rst0_resp_rdata", resp_rdata0, 0);
    chk("rst_byte8", dut.u_mem.mem[8], 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Store then load at 8; first acceptance on the first edge after release.
    do_txn(0, 1'b1, 5'd8, 32'hDEADBEEF, 0, 0, rd, er, lat);
    chk("st8_lat", lat, 3);
    chk("st8_rdata", rd, 32'h0);
    chk("st8_err", er, 0);
    chk("byte8", dut.u_mem.mem[8], 8'hDE);
    chk("byte9", dut.u_mem.mem[9], 8'hAD);
    chk("byte10", dut.u_mem.mem[10], 8'hBE);
    chk("byte11", dut.u_mem.mem[11], 8'hEF);
    do_txn(0, 1'b0, 5'd8, 32'h0, 0, 0, rd, er, lat);
    chk("ld8_lat", lat, 3);
    chk("ld8_rdata", rd, 32'hDEADBEEF);
    chk("ld8_err", er, 0);

    // Misaligned load errors, neighbouring word still zero.
    do_txn(0, 1'b0, 5'd6, 32'h0, 0, 0, rd, er, lat);
    chk("ld6_err", er, 1);
    chk("ld6_rdata", rd, 32'h0);
    do_txn(0, 1'b0, 5'd4, 32'h0, 0, 0, rd, er, lat);
    chk("ld4_rdata", rd, 32'h0);
    chk("ld4_err", er, 0);

    // Held response with req_valid kept high throughout.
    do_txn(0, 1'b0, 5'd8, 32'h0, 5, 1, rd, er, lat);
    chk("hold_ld8_rdata", rd, 32'hDEADBEEF);

    // Request fields wander during the wait; only captured values count.
    do_txn(0, 1'b1, 5'd12, 32'hA5A55A5A, 1, 1, rd, er, lat);
    chk("st12_rdata", rd, 32'h0);
    chk("st12_err", er, 0);
    do_txn(0, 1'b0, 5'd12, 32'h0, 0, 0, rd, er, lat);
    chk("ld12_rdata", rd, 32'hA5A55A5A);
    do_txn(0, 1'b0, 5'd8, 32'h0, 0, 0, rd, er, lat);
    chk("ld8_again_rdata", rd, 32'hDEADBEEF);

    // Reset in the middle of the wait of a store to address 0.
    sel0 = 1'b0; req_write = 1'b1; req_addr = 5'd0; req_wdata = 32'hFFFFFFFF; tb_valid = 1'b1;
    @(posedge clk); #2;
    tb_valid = 1'b0;
    @(posedge clk); #2;
    chk("midwait_req_ready", req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_req_ready", req_ready, 1);
    chk("async_resp_valid", resp_valid, 0);
    chk("async_resp_rdata", resp_rdata, 0);
    chk("async_resp_err", resp_err, 0);
    chk("async_byte8", dut.u_mem.mem[8], 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stray_resp", resp_valid, 0);
    end
    @(posedge clk); #2;
    do_txn(0, 1'b0, 5'd0, 32'h0, 0, 0, rd, er, lat);
    chk("ld0_after_rst", rd, 32'h0);
    chk("ld0_after_rst_lat", lat, 3);

    // Zero-wait instance: store and load at the top word.
    do_txn(1, 1'b1, 5'd28, 32'h12345678, 0, 0, rd, er, lat);
    chk("w0_st28_lat", lat, 1);
    chk("w0_st28_err", er, 0);
    chk("w0_byte28", dut0.u_mem.mem[28], 8'h12);
    chk("w0_byte31", dut0.u_mem.mem[31], 8'h78);
    do_txn(1, 1'b0, 5'd28, 32'h0, 0, 0, rd, er, lat);
    chk("w0_ld28_lat", lat, 1);
    chk("w0_ld28_rdata", rd, 32'h12345678);
    chk("w0_ld28_err", er, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
